// File: rtl/calc_sequencer.sv
// Host-side sequencer for the calculator FSM: accepts one request, feeds start/A/B,
// waits for completion (with timeout) and holds the response until the host takes it.
module calc_sequencer #(
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [3:0] req_a,
  input  logic [3:0] req_b,
  input  logic [2:0] req_op,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_result,
  output logic       rsp_err,
  output logic       calc_start,
  output logic [3:0] calc_digit,
  output logic       calc_enter,
  output logic [2:0] calc_op,
  input  logic [7:0] calc_result,
  input  logic       calc_done,
  output logic       busy
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_A     = 3'd2;
  localparam logic [2:0] S_B     = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;
  localparam logic [2:0] S_RESP  = 3'd5;

  logic [2:0]    state;
  logic [3:0]    a_lat;
  logic [3:0]    b_lat;
  logic [2:0]    op_lat;
  logic [CW-1:0] count;
  logic [7:0]    shadow;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      a_lat      <= 4'd0;
      b_lat      <= 4'd0;
      op_lat     <= 3'd0;
      count      <= '0;
      shadow     <= 8'd0;
      rsp_result <= 8'd0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            a_lat  <= req_a;
            b_lat  <= req_b;
            op_lat <= req_op;
            state  <= S_START;
          end
        end
        S_START: state <= S_A;
        S_A:     state <= S_B;
        S_B: begin
          count <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          // The calculator zeroes its result in the done cycle, so the
          // response comes from the value sampled one cycle earlier.
          shadow <= calc_result;
          if (calc_done) begin
            rsp_result <= shadow;
            rsp_err    <= 1'b0;
            state      <= S_RESP;
          end else if (count == CW'(TIMEOUT - 1)) begin
            rsp_result <= 8'hFF;
            rsp_err    <= 1'b1;
            state      <= S_RESP;
          end else begin
            count <= count + 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign req_ready  = (state == S_IDLE);
  assign busy       = (state != S_IDLE);
  assign rsp_valid  = (state == S_RESP);
  assign calc_start = (state == S_START);
  assign calc_enter = (state == S_A) || (state == S_B);
  assign calc_digit = (state == S_A) ? a_lat :
                      (state == S_B) ? b_lat : 4'd0;
  assign calc_op    = ((state == S_START) || (state == S_A) ||
                       (state == S_B) || (state == S_WAIT)) ? op_lat : 3'd0;

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer with a behavioural calculator model
// (result in its CALC cycle, done the cycle after, result zero otherwise).
module tb_calc_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [3:0] req_a = 4'd0;
  logic [3:0] req_b = 4'd0;
  logic [2:0] req_op = 3'd0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_result;
  logic       rsp_err;
  logic       calc_start;
  logic [3:0] calc_digit;
  logic       calc_enter;
  logic [2:0] calc_op;
  logic [7:0] calc_result;
  logic       calc_done;
  logic       busy;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  calc_sequencer #(.TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_err(rsp_err),
    .calc_start(calc_start), .calc_digit(calc_digit),
    .calc_enter(calc_enter), .calc_op(calc_op),
    .calc_result(calc_result), .calc_done(calc_done),
    .busy(busy)
  );

  // Calculator model: phase 1 expects A, 2 expects B, 3 internal, 4 CALC, 5 DONE.
  int         m_phase = 0;
  logic [3:0] ma = 4'd0;
  logic [3:0] mb = 4'd0;
  logic [2:0] mop = 3'd0;
  logic       done_en = 1'b1;
  int         done_seen = 0;

  function automatic logic [7:0] calc_fn(input logic [3:0] a, input logic [3:0] b,
                                         input logic [2:0] op);
    case (op)
      3'd0:    return {4'd0, a} + {4'd0, b};
      3'd1:    return {4'd0, a} - {4'd0, b};
      3'd2:    return {4'd0, a & b};
      3'd3:    return {4'd0, a | b};
      3'd4:    return {4'd0, a} * {4'd0, b};
      default: return {4'd0, a ^ b};
    endcase
  endfunction

  always @(posedge clk) begin
    if (calc_done) done_seen <= done_seen + 1;
    if (calc_start) m_phase <= 1;
    else begin
      case (m_phase)
        1: if (calc_enter) begin ma <= calc_digit; m_phase <= 2; end
        2: if (calc_enter) begin mb <= calc_digit; mop <= calc_op; m_phase <= 3; end
        3: m_phase <= 4;
        4: m_phase <= 5;
        5: m_phase <= 0;
        default: m_phase <= 0;
      endcase
    end
  end

  assign calc_result = (m_phase == 4) ? calc_fn(ma, mb, mop) : 8'h00;
  assign calc_done   = (m_phase == 5) && done_en;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Handshake in the current cycle (cycle 0); returns at the negedge of cycle 1.
  task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    check("accept_ready", req_ready, 1);
    req_valid = 1'b1;
    req_a = a;
    req_b = b;
    req_op = op;
    step();
    req_valid = 1'b0;
  endtask

  int seen0;

  initial begin
    // Reset state
    step();
    check("rst_req_ready", req_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_result", rsp_result, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_calc_outs", {calc_start, calc_enter, calc_digit, calc_op}, 0);
    rst = 1'b0;
    step();

    // 5 + 3, op 000, cycle-accurate latency
    rsp_ready = 1'b1;
    send(4'd5, 4'd3, 3'd0);
    check("t1_c1_start", calc_start, 1);
    check("t1_c1_busy", busy, 1);
    check("t1_c1_ready", req_ready, 0);
    check("t1_c1_enter", calc_enter, 0);
    step();
    check("t1_c2_enter", calc_enter, 1);
    check("t1_c2_digit", calc_digit, 5);
    check("t1_c2_start", calc_start, 0);
    step();
    check("t1_c3_enter", calc_enter, 1);
    check("t1_c3_digit", calc_digit, 3);
    step();
    check("t1_c4_enter", calc_enter, 0);
    check("t1_c4_digit", calc_digit, 0);
    check("t1_c4_valid", rsp_valid, 0);
    step();
    check("t1_c5_valid", rsp_valid, 0);
    step();
    check("t1_c6_valid", rsp_valid, 0);
    step();
    check("t1_c7_valid", rsp_valid, 1);
    check("t1_c7_result", rsp_result, 8'h08);
    check("t1_c7_err", rsp_err, 0);
    step();
    check("t1_c8_valid", rsp_valid, 0);
    check("t1_c8_busy", busy, 0);

    // 15 * 15, op held, response held under backpressure
    rsp_ready = 1'b0;
    send(4'd15, 4'd15, 3'd4);
    for (int c = 1; c <= 6; c++) begin
      check($sformatf("t2_c%0d_op", c), calc_op, 4);
      step();
    end
    check("t2_c7_valid", rsp_valid, 1);
    check("t2_c7_result", rsp_result, 8'hE1);
    check("t2_c7_op", calc_op, 0);
    for (int i = 0; i < 5; i++) begin
      req_valid = (i % 2 == 0);
      req_a = 4'(i);
      step();
      check($sformatf("t2_hold%0d_valid", i), rsp_valid, 1);
      check($sformatf("t2_hold%0d_result", i), rsp_result, 8'hE1);
      check($sformatf("t2_hold%0d_err", i), rsp_err, 0);
      check($sformatf("t2_hold%0d_ready", i), req_ready, 0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    step();
    check("t2_done_valid", rsp_valid, 0);
    check("t2_done_busy", busy, 0);
    step();
    check("t2_no_accept", {busy, calc_start}, 0);

    // Timeout: calculator never completes
    done_en = 1'b0;
    send(4'd1, 4'd2, 3'd0);
    step(); step(); step();
    for (int c = 4; c <= 18; c++) begin
      check($sformatf("t3_c%0d_valid", c), rsp_valid, 0);
      step();
    end
    check("t3_c19_valid", rsp_valid, 1);
    check("t3_c19_err", rsp_err, 1);
    check("t3_c19_result", rsp_result, 8'hFF);
    step();
    check("t3_c20_busy", busy, 0);
    done_en = 1'b1;
    step();

    // Reset during WAIT discards the transaction
    send(4'd9, 4'd4, 3'd0);
    step(); step(); step();
    check("t4_c4_busy", busy, 1);
    seen0 = done_seen;
    rst = 1'b1;
    #1;
    check("t4_async_busy", busy, 0);
    check("t4_async_ready", req_ready, 1);
    check("t4_async_op", calc_op, 0);
    step();
    rst = 1'b0;
    for (int c = 6; c <= 11; c++) begin
      step();
      check($sformatf("t4_c%0d_valid", c), rsp_valid, 0);
      check($sformatf("t4_c%0d_busy", c), busy, 0);
    end
    check("t4_model_done", done_seen - seen0, 1);
    check("t4_result_cleared", rsp_result, 0);
    send(4'd2, 4'd7, 3'd3);
    for (int c = 2; c <= 7; c++) step();
    check("t4b_valid", rsp_valid, 1);
    check("t4b_result", rsp_result, 8'h07);
    check("t4b_err", rsp_err, 0);
    step();

    // Back-to-back with rsp_ready high
    req_valid = 1'b1;
    req_a = 4'd6;
    req_b = 4'd7;
    req_op = 3'd4;
    step();
    req_a = 4'd12;
    req_b = 4'd10;
    req_op = 3'd0;
    for (int c = 1; c <= 6; c++) begin
      check($sformatf("t5_c%0d_ready", c), req_ready, 0);
      if (c == 2) check("t5_c2_digit", calc_digit, 6);
      step();
    end
    check("t5_c7_valid", rsp_valid, 1);
    check("t5_c7_result", rsp_result, 8'h2A);
    step();
    check("t5_c8_ready", req_ready, 1);
    check("t5_c8_busy", busy, 0);
    step();
    req_valid = 1'b0;
    check("t5_c9_start", calc_start, 1);
    step();
    check("t5_c10_digit", calc_digit, 12);
    step();
    check("t5_c11_digit", calc_digit, 10);
    step(); step(); step(); step();
    check("t5_c15_valid", rsp_valid, 1);
    check("t5_c15_result", rsp_result, 8'h16);
    check("t5_c15_err", rsp_err, 0);
    step();
    check("t5_c16_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/calc_sequencer.md
CALC_SEQUENCER -- requirements
Module: calc_sequencer

Interface
REQ-001 Parameter TIMEOUT, default 15, max cycles in S_WAIT without calc_done before an error response.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req_valid  input  1  host request present.
REQ-005 req_ready  output  1  sequencer can accept a request.
REQ-006 req_a  input  4  operand A.
REQ-007 req_b  input  4  operand B.
REQ-008 req_op  input  3  operation code, passed unchanged to calculator.
REQ-009 rsp_valid  output  1  response present.
REQ-010 rsp_ready  input  1  host accepts response.
REQ-011 rsp_result  output  8  captured calculator result.
REQ-012 rsp_err  output  1  response is a timeout error.
REQ-013 calc_start  output  1  start strobe to calculator FSM.
REQ-014 calc_digit  output  4  operand digit to calculator.
REQ-015 calc_enter  output  1  digit-enter strobe to calculator.
REQ-016 calc_op  output  3  operation code to calculator.
REQ-017 calc_result  input  8  calculator result, valid only in calculator CALC cycle, zero otherwise.
REQ-018 calc_done  input  1  calculator completion, high one cycle, the cycle after CALC.
REQ-019 busy  output  1  high in every state except S_IDLE.

Function
REQ-020 States S_IDLE, S_START, S_A, S_B, S_WAIT, S_RESP; all calc_* and rsp_* outputs registered or decoded from state only.
REQ-021 req_ready = 1 only in S_IDLE; handshake on req_valid && req_ready latches req_a, req_b, req_op, moves to S_START.
REQ-022 S_START: calc_start=1 for exactly one cycle; next S_A.
REQ-023 S_A: calc_enter=1, calc_digit=latched A, one cycle; next S_B.
REQ-024 S_B: calc_enter=1, calc_digit=latched B, one cycle; next S_WAIT, timeout counter cleared to 0.
REQ-025 calc_start and calc_enter 0 in all other states; calc_digit 0 outside S_A/S_B.
REQ-026 calc_op holds latched op from S_START until leaving S_WAIT, 0 otherwise.
REQ-027 Shadow register samples calc_result every cycle in S_WAIT; calculator drives result 0 in its done cycle, so only the shadow value is used.
REQ-028 S_WAIT with calc_done=1: rsp_result <= shadow (value from previous cycle), rsp_err <= 0, next S_RESP.
REQ-029 S_WAIT without calc_done: counter increments; when counter reaches TIMEOUT-1, rsp_result <= 8'hFF, rsp_err <= 1, next S_RESP.
REQ-030 calc_done and timeout in same cycle: calc_done wins, rsp_err=0.
REQ-031 S_RESP: rsp_valid=1; rsp_result, rsp_err stable until rsp_valid && rsp_ready; then S_IDLE.
REQ-032 calc_done outside S_WAIT ignored; no state or output change.
REQ-033 Latency with well-behaved calculator: accept at cycle 0, calc_start cycle 1, A enter cycle 2, B enter cycle 3, calc_done cycle 6, rsp_valid first high cycle 7.
REQ-034 Back-to-back: request accepted at earliest one cycle after response handshake (S_IDLE cycle); no request accepted while busy.

Reset
REQ-035 rst=1 forces S_IDLE immediately, regardless of clock.
REQ-036 Reset values: req_ready=1 once in S_IDLE, rsp_valid=0, rsp_result=0, rsp_err=0, calc_start=0, calc_enter=0, calc_digit=0, calc_op=0, busy=0, counter=0, shadow=0, latched operands 0.
REQ-037 Reset mid-transaction (any state) discards the transaction; no response emitted afterwards.

Verification
REQ-038 Bench uses behavioural calculator model of the same protocol: a=5, b=3, op=000 -> rsp_result=8'h08, rsp_err=0, rsp_valid at cycle 7.
REQ-039 a=15, b=15, op=100 -> rsp_result=8'hE1; calc_op=100 held from cycle 1 through cycle 6.
REQ-040 rsp_ready held low 5 cycles after rsp_valid -> rsp_result/rsp_err unchanged, req_ready=0, req_valid pulses ignored.
REQ-041 Model never asserts calc_done, TIMEOUT=15 -> rsp_valid with rsp_err=1, rsp_result=8'hFF, 15 cycles after entering S_WAIT.
REQ-042 rst pulsed during S_WAIT, then model asserts calc_done -> no rsp_valid; next request a=2, b=7, op=011 -> rsp_result=8'h07.
REQ-043 Two requests back-to-back, rsp_ready tied high -> second accepted one cycle after first response; results correct for both.
